// File: rtl/mult_product_stage.sv
// rtl/mult_product_stage.sv - sequential 8x8 shift-and-add multiplier filling the product buffer
//
// On a start arm-then-release handshake, reads N_WORDS operand words {a,b},
// computes each exact 16-bit product a*b over 8 shift-and-add cycles, and
// writes it to the product buffer at the same index. Then pulses done.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    run request (level arms, falling level launches the run)
//   rd_addr  operand memory address (= idx)
//   rd_data  operand word {a[15:8], b[7:0]}, combinational read
//   wr_en    product buffer write strobe, one cycle per entry
//   wr_addr  product buffer address (= idx)
//   wr_data  exact product (= acc)
//   busy     high in every state except IDLE
//   done     one-cycle pulse at end of run
module mult_product_stage #(
    parameter int N_WORDS = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] rd_addr,
    input  logic [15:0]   rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FETCH,
        MUL,
        WRITE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] idx;
    logic [15:0]   a_sh;
    logic [7:0]    b_sh;
    logic [15:0]   acc;
    logic [2:0]    cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nxt = ARM;
            ARM:   if (!start) state_nxt = FETCH;
            FETCH: state_nxt = MUL;
            // cnt counts 0..7, so the eighth MUL cycle is the one with cnt==7
            MUL:   if (cnt == 3'd7) state_nxt = WRITE;
            WRITE: begin
                wr_en     = 1'b1;
                state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                ARM: idx <= '0;
                FETCH: begin
                    // rd_data is captured only here; later changes cannot disturb the product
                    a_sh <= {8'b0, rd_data[15:8]};
                    b_sh <= rd_data[7:0];
                    acc  <= '0;
                    cnt  <= '0;
                end
                MUL: begin
                    // a<=255 and b<=255 keep the running sum within 16 bits
                    if (b_sh[0]) acc <= acc + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 3'd1;
                end
                WRITE: if (idx != LAST_IDX) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_addr = idx;
    assign wr_addr = idx;
    assign wr_data = acc;

endmodule

// File: tb/tb_mult_product_stage.sv
// tb/tb_mult_product_stage.sv - self-checking bench for mult_product_stage
module tb_mult_product_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  rd_addr;
    logic [3:0]  wr_addr;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    logic [15:0] mem [16];
    logic [15:0] rnd;
    bit          rand_en = 1'b0;
    bit          noise = 1'b0;

    // model: m_st 0=idle 1=armed 2=running; m_t = cycles since FETCH of entry 0
    int m_st = 0;
    int m_t = 0;

    int checks = 0;
    int failures = 0;

    logic [15:0] pbuf [16];
    bit          written [16];
    int          wcount = 0;
    int          dcount = 0;

    // operand word is only guaranteed stable in the cycle the model calls a fetch
    assign rd_data = (rand_en && !(m_st == 2 && m_t < 160 && m_t % 10 == 0)) ? rnd : mem[rd_addr];

    always @(negedge clk) rnd = 16'($urandom);

    mult_product_stage #(.N_WORDS(16), .AW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st = 0;
            m_t  = 0;
        end else begin
            case (m_st)
                0: if (start) m_st = 1;
                1: if (!start) begin m_st = 2; m_t = 0; end
                default: if (m_t == 160) m_st = 0; else m_t++;
            endcase
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (!rst) begin
            chk("reset_outs", {14'd0, busy, wr_en, done, rd_addr, wr_addr, wr_data}, 32'd0);
        end else begin
            logic        exp_wr;
            logic        exp_done;
            int          k;
            logic [31:0] prod;
            exp_wr   = (m_st == 2 && m_t < 160 && m_t % 10 == 9);
            exp_done = (m_st == 2 && m_t == 160);
            k        = (m_t < 160) ? m_t / 10 : 15;
            chk("busy", busy, m_st != 0);
            chk("wr_en", wr_en, exp_wr);
            chk("done", done, exp_done);
            if (m_st == 2) begin
                chk("rd_addr", rd_addr, k);
                chk("wr_addr", wr_addr, k);
            end
            if (exp_wr) begin
                prod = mem[k][15:8] * mem[k][7:0];
                chk("wr_data", wr_data, prod);
            end
            if (wr_en) begin
                pbuf[wr_addr]    = wr_data;
                written[wr_addr] = 1'b1;
                wcount++;
            end
            if (done) dcount++;
        end
    end

    task automatic clear_buf();
        for (int i = 0; i < 16; i++) begin
            pbuf[i]    = 16'h0;
            written[i] = 1'b0;
        end
        wcount = 0;
        dcount = 0;
    endtask

    task automatic pulse_start(input int cycles);
        @(negedge clk);
        start = 1'b1;
        repeat (cycles) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n++;
            if (noise) start = (m_st == 2 && m_t < 150) ? 1'($urandom % 2) : 1'b0;
            if (done) break;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [5:0] mask;

        for (int i = 0; i < 16; i++) mem[i] = {8'(i + 1), 8'(2 * i + 3)};
        clear_buf();

        repeat (3) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // full run
        clear_buf();
        pulse_start(3);
        wait_done(n);
        chk("done_latency", n, 161);
        chk("full_wcount", wcount, 16);
        chk("full_dcount", dcount, 1);
        chk("entry0", pbuf[0], 16'h0003);
        chk("entry15", pbuf[15], 16'h0210);

        // corner operands
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hFFFF; mem[1] = 16'h00FF; mem[2] = 16'hFF00;
        mem[3] = 16'h0101; mem[4] = 16'h8002;
        clear_buf();
        pulse_start(1);
        wait_done(n);
        chk("corner_ffff", pbuf[0], 16'hFE01);
        chk("corner_00ff", pbuf[1], 16'h0000);
        chk("corner_ff00", pbuf[2], 16'h0000);
        chk("corner_0101", pbuf[3], 16'h0001);
        chk("corner_8002", pbuf[4], 16'h0100);

        // random operands with start and rd_data noise during the run
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            clear_buf();
            rand_en = 1'b1;
            noise   = 1'b1;
            pulse_start(2);
            wait_done(n);
            rand_en = 1'b0;
            noise   = 1'b0;
            chk("noise_latency", n, 161);
            chk("noise_wcount", wcount, 16);
            chk("noise_dcount", dcount, 1);
            chk("noise_busy_after", busy, 1'b0);
        end

        // reset during MUL of entry 5
        clear_buf();
        pulse_start(2);
        for (int c = 0; c < 200 && !(m_st == 2 && m_t == 53); c++) @(negedge clk);
        chk("reach_mul5", m_t, 53);
        rst = 1'b0;
        #1;
        chk("midrun_reset_outs", {busy, wr_en, done, rd_addr, wr_addr, wr_data}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) mask[i] = written[i];
        chk("partial_written", mask, 6'b011111);
        chk("partial_wcount", wcount, 5);
        clear_buf();
        pulse_start(1);
        wait_done(n);
        chk("rerun_wcount", wcount, 16);
        chk("rerun_latency", n, 161);

        // start held high for 50 cycles
        clear_buf();
        @(negedge clk);
        start = 1'b1;
        repeat (50) @(negedge clk);
        chk("hold_busy", busy, 1'b1);
        chk("hold_nowrite", wcount, 0);
        start = 1'b0;
        wait_done(n);
        chk("hold_latency", n, 161);
        chk("hold_dcount", dcount, 1);
        chk("hold_wcount", wcount, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_product_stage.md
# mult_product_stage

Sequential 8x8 unsigned shift-and-add multiplier stage that fills the 16-entry product buffer. It sits directly upstream of the leading-one/truncation controller. On a start handshake it reads 16 operand words from the operand memory, computes each exact 16-bit product, and writes it to the product buffer at the same index. It then pulses `done`, which drives the downstream controller's `start` input.

## Interface

- N_WORDS, 16, number of operand/product entries processed per run
- AW, 4, address width; 2^AW must equal N_WORDS

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset; all state clears while low
- start  in  1  run request; level high arms the block, and the run begins once start returns low
- rd_addr  out  AW  operand memory address; equals the index register
- rd_data  in  16  operand word {a[15:8], b[7:0]}, unsigned; combinational read, valid in the same cycle as rd_addr
- wr_en  out  1  product buffer write strobe; one cycle per entry
- wr_addr  out  AW  product buffer address
- wr_data  out  16  exact product a*b
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run; wired to the downstream start

## Operation

- Registers:
  - idx[AW-1:0]
  - a_sh[15:0], the multiplicand shifted left
  - b_sh[7:0], the multiplier shifted right
  - acc[15:0]
  - cnt[2:0]
- Moore FSM; outputs decode from the present state only. rd_addr=idx, wr_addr=idx, wr_data=acc at all times.
- States and transitions:
  - IDLE: go to ARM if start=1, else stay.
  - ARM: idx<=0; stay while start=1, go to FETCH when start=0.
  - FETCH: a_sh<={8'b0, rd_data[15:8]}, b_sh<=rd_data[7:0], acc<=0, cnt<=0. Go to MUL.
  - MUL, every cycle:
    - if b_sh[0], acc<=acc+a_sh (16-bit, never overflows);
    - a_sh<=a_sh<<1; b_sh<=b_sh>>1; cnt<=cnt+1.
    - Exactly 8 cycles; leave to WRITE when cnt==7.
  - WRITE: wr_en=1. Go to DONE if idx==N_WORDS-1, else idx<=idx+1 and go to FETCH.
  - DONE: done=1. Go to IDLE.
- Arithmetic: unsigned and exact. The maximum product is 255*255=65025 (0xFE01). No approximation in this stage.
- start is ignored in FETCH/MUL/WRITE/DONE; a new run requires a fresh rise while in IDLE.
- rd_data is sampled only in FETCH; changes during MUL do not affect the current product.
- Reset values:
  - state=IDLE
  - idx, a_sh, b_sh, acc, cnt = 0
  - wr_en=0, done=0, busy=0
  - rd_addr=0, wr_addr=0, wr_data=0
- Reset mid-run: the state returns to IDLE immediately and asynchronously. No further wr_en occurs. Partial buffer contents are left as written.

## Timing

- Per entry: FETCH 1 cycle + MUL 8 cycles + WRITE 1 cycle = 10 cycles.
- Run length: FETCH of entry 0 is the first clock edge after start is sampled low in ARM.
  - wr_en for entry k is high in cycle 10k+9, counting that FETCH cycle as cycle 0.
  - done is high in cycle 160; IDLE follows in cycle 161.
- done is high for exactly one cycle, then low. This matches the downstream arm-then-release start convention.
- wr_en and wr_addr/wr_data are valid together in the same cycle; the buffer captures on that cycle's rising edge.
- Start held high indefinitely keeps the FSM in ARM with no memory activity.
- There are no back-to-back runs without passing through IDLE. The minimum gap is DONE, then IDLE, then ARM.

## Test plan

- Reset state: hold rst low with start toggling -> every output is 0 and there is no wr_en. Release rst -> IDLE, busy=0.
- Full run: operand memory holds entry i = {i+1, 2i+3}; pulse start for 3 cycles -> exactly 16 wr_en pulses, 10 cycles apart, each with wr_data=(i+1)*(2i+3). Entry 15 gives 16*33=528 (0x0210). done is high exactly 160 cycles after FETCH of entry 0.
- Corner operands:
  - 0xFFFF gives 0xFE01;
  - 0x00FF and 0xFF00 give 0x0000;
  - 0x0101 gives 0x0001;
  - 0x8002 gives 0x0100.
- Stimulus independence: start pulsed again during MUL and rd_data randomised during MUL -> the run is unaffected, the products are correct, and no second run occurs.
- Reset mid-run: assert rst during MUL of entry 5 -> outputs go to 0 immediately, entries 0-4 are already written, and there is no wr_en for entry 5. A later start performs a full 16-entry run from idx=0.
- Handshake: hold start high for 50 cycles -> FSM stays in ARM, busy=1, no writes. The run begins the cycle after start falls, and done pulses once.
